// File: rtl/cnn_acc_requant_22s_14s.sv
// cnn_acc_requant_22s_14s: saturating product accumulator with bias, round-half-up requantization, optional ReLU and output clamp (in: in_valid/in_ready/in_data/in_last/bias_in, out: out_valid/out_ready/out_data/out_ovf, ap_clk, ap_rst sync active-high)
module cnn_acc_requant_22s_14s #(
  parameter int PROD_W = 22,
  parameter int ACC_W = 30,
  parameter int OUT_W = 14,
  parameter int SHIFT = 6,
  parameter int RELU = 0,
  parameter int MAX_BEATS = 256
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic                     in_last,
  input  logic signed [OUT_W-1:0]  bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_ovf
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic signed [ACC_W+1:0] AMAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] AMIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
  typedef enum logic [1:0] {IDLE, ACC, RND, OUT} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic ovf, take, done, sat_hi, sat_lo, clamp_hi, clamp_lo;
  logic signed [ACC_W+1:0] base, prod, sum;
  logic signed [ACC_W:0] rnd, r, rr;
  assign in_ready = state == IDLE || state == ACC;
  assign out_valid = state == OUT;
  assign take = in_valid && in_ready;
  always_comb begin
    prod = {{(ACC_W+2-PROD_W){in_data[PROD_W-1]}}, in_data};
    base = state == IDLE ? {{(ACC_W+2-OUT_W){bias_in[OUT_W-1]}}, bias_in} << SHIFT : {{2{acc[ACC_W-1]}}, acc};
    sum = base + prod;
    sat_hi = sum > AMAX;
    sat_lo = sum < AMIN;
    acc_nx = sat_hi ? AMAX[ACC_W-1:0] : sat_lo ? AMIN[ACC_W-1:0] : sum[ACC_W-1:0];
    cnt_nx = state == IDLE ? CNT_W'(1) : cnt + 1'b1;
    done = in_last || cnt_nx == CNT_W'(MAX_BEATS);
    rnd = {acc[ACC_W-1], acc} + HALF;
    r = rnd >>> SHIFT;
    rr = (RELU != 0 && r < 0) ? '0 : r;
    clamp_hi = rr > OMAX;
    clamp_lo = rr < OMIN;
    state_nx = state == OUT ? (out_ready ? IDLE : OUT) :
               state == RND ? OUT :
               take ? (done ? RND : ACC) : state;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (take) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        ovf <= (state == ACC && ovf) || sat_hi || sat_lo;
      end
      if (state == RND) begin
        out_data <= clamp_hi ? OMAX[OUT_W-1:0] : clamp_lo ? OMIN[OUT_W-1:0] : rr[OUT_W-1:0];
        out_ovf <= ovf || clamp_hi || clamp_lo;
      end
      if (out_valid && out_ready) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cnn_acc_requant_22s_14s.sv
// tb_cnn_acc_requant_22s_14s: directed self-checking bench for the accumulate/requantize block
module tb_cnn_acc_requant_22s_14s;
  logic clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [2:0] vin = 3'b000;
  logic signed [21:0] in_data = '0;
  logic in_last = 1'b0;
  logic signed [13:0] bias_in = '0;
  logic out_ready = 1'b0;
  logic rdy [3];
  logic ov [3];
  logic ovo [3];
  logic signed [13:0] od [3];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  cnn_acc_requant_22s_14s dut (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(vin[0]), .in_ready(rdy[0]), .in_data(in_data),
    .in_last(in_last), .bias_in(bias_in), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ovf(ovo[0]));
  cnn_acc_requant_22s_14s #(.RELU(1)) dut_relu (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(vin[1]), .in_ready(rdy[1]), .in_data(in_data),
    .in_last(in_last), .bias_in(bias_in), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ovf(ovo[1]));
  cnn_acc_requant_22s_14s #(.MAX_BEATS(4)) dut_mb (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(vin[2]), .in_ready(rdy[2]), .in_data(in_data),
    .in_last(in_last), .bias_in(bias_in), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_ovf(ovo[2]));
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic beat(input int w, input int d, input bit l, input int b);
    int n = 0;
    in_data = 22'(d);
    in_last = l;
    bias_in = 14'(b);
    vin[w] = 1'b1;
    while (!rdy[w] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_ready", rdy[w], 1);
    @(posedge clk); #1;
    vin[w] = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic get_result(input int w, input int d, input int o, input string tag);
    int n = 0;
    while (!ov[w] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, ov[w], 1);
    chk({tag, "_data"}, od[w], d);
    chk({tag, "_ovf"}, ovo[w], o);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done"}, ov[w], 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ov[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_ovf", ovo[0], 0);
    ap_rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", rdy[0], 1);
    beat(0, 64, 0, 0);
    beat(0, 64, 1, 0);
    chk("lat_rnd_valid", ov[0], 0);
    chk("lat_rnd_ready", rdy[0], 0);
    @(posedge clk); #1;
    chk("lat_out_valid", ov[0], 1);
    get_result(0, 2, 0, "two_beats");
    beat(0, 32, 1, 0);
    get_result(0, 1, 0, "rnd_32");
    beat(0, 31, 1, 0);
    get_result(0, 0, 0, "rnd_31");
    beat(0, -96, 1, 0);
    get_result(0, -1, 0, "rnd_m96");
    beat(1, -96, 1, 0);
    get_result(1, 0, 0, "relu_m96");
    beat(1, 96, 1, 0);
    get_result(1, 2, 0, "relu_96");
    beat(0, 0, 1, 5);
    get_result(0, 5, 0, "bias5");
    beat(0, 64, 0, 5);
    beat(0, 64, 1, 100);
    get_result(0, 7, 0, "bias_ignored");
    for (int i = 0; i < 4; i++) beat(0, 2097151, i == 3, 0);
    get_result(0, 8191, 1, "sat_pos");
    for (int i = 0; i < 4; i++) beat(0, -2097152, i == 3, 0);
    get_result(0, -8192, 1, "sat_neg");
    beat(0, 32, 1, 0);
    get_result(0, 1, 0, "ovf_cleared");
    beat(0, 64, 0, 0);
    beat(0, 64, 1, 0);
    @(posedge clk); #1;
    vin[0] = 1'b1;
    in_data = 22'(1000);
    in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_data", od[0], 2);
      chk("bp_valid", ov[0], 1);
      chk("bp_ready", rdy[0], 0);
    end
    vin[0] = 1'b0;
    in_last = 1'b0;
    get_result(0, 2, 0, "bp");
    beat(0, 32, 1, 0);
    get_result(0, 1, 0, "after_bp");
    for (int i = 0; i < 4; i++) beat(2, 64, 0, 0);
    chk("mb_forced_end", rdy[2], 0);
    get_result(2, 4, 0, "mb_first");
    beat(2, 64, 0, 0);
    beat(2, 64, 1, 0);
    get_result(2, 2, 0, "mb_second");
    beat(0, 64, 0, 0);
    beat(0, 64, 0, 0);
    ap_rst = 1'b1;
    @(posedge clk); #1;
    ap_rst = 1'b0;
    chk("rst_mid_ready", rdy[0], 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_valid", ov[0], 0);
    beat(0, 32, 1, 0);
    get_result(0, 1, 0, "after_rst_mid");
    beat(0, 128, 1, 0);
    @(posedge clk); #1;
    chk("pre_rst_out_valid", ov[0], 1);
    ap_rst = 1'b1;
    @(posedge clk); #1;
    ap_rst = 1'b0;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_data", od[0], 0);
    beat(0, -32, 1, 0);
    get_result(0, 0, 0, "after_rst_out");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
